// File: rtl/traffic_pkg.sv
// Shared road indices, default thresholds and emergency-grant FSM encoding for the traffic sensor encoder.
// TRAFFIC_EMG_TIMEOUT_EN adds the default emergency grant timeout constant.
package traffic_pkg;

    localparam int ROAD_SOUTH = 0;
    localparam int ROAD_WEST  = 1;
    localparam int ROAD_NORTH = 2;
    localparam int ROAD_EAST  = 3;
    localparam int NUM_ROADS  = 4;

    localparam int DEF_CNT_W      = 6;
    localparam int DEF_JAM_ON     = 20;
    localparam int DEF_JAM_OFF    = 14;
    localparam int DEF_EMPTY_HOLD = 8;
    localparam int DEF_SIREN_HOLD = 4;
`ifdef TRAFFIC_EMG_TIMEOUT_EN
    localparam int DEF_EMG_MAX    = 200;
`endif

    typedef enum logic [2:0] {
        EMG_IDLE,
        EMG_SOUTH,
        EMG_WEST,
        EMG_NORTH,
        EMG_EAST
    } emg_state_t;

    function automatic logic [1:0] grant_road(input emg_state_t s);
        case (s)
            EMG_WEST:  return 2'(ROAD_WEST);
            EMG_NORTH: return 2'(ROAD_NORTH);
            EMG_EAST:  return 2'(ROAD_EAST);
            default:   return 2'(ROAD_SOUTH);
        endcase
    endfunction

    function automatic logic [3:0] road_onehot(input logic [1:0] r);
        return 4'b0001 << r;
    endfunction

endpackage

// File: rtl/road_occupancy_channel.sv
// One road's occupancy counter with jam hysteresis, empty hold timer and sticky occupancy error.
module road_occupancy_channel
    import traffic_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int JAM_ON     = DEF_JAM_ON,
    parameter int JAM_OFF    = DEF_JAM_OFF,
    parameter int EMPTY_HOLD = DEF_EMPTY_HOLD
) (
    input  logic clk,
    input  logic rst,
    input  logic arrive,
    input  logic depart,
    output logic jam,
    output logic empty,
    output logic occ_err
);

    localparam int EW = $clog2(EMPTY_HOLD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] JAM_ON_C  = CNT_W'(JAM_ON);
    localparam logic [CNT_W-1:0] JAM_OFF_C = CNT_W'(JAM_OFF);
    localparam logic [EW-1:0]    HOLD_C    = EW'(EMPTY_HOLD);

    logic [CNT_W-1:0] count;
    logic [EW-1:0]    zero_run;

    // Jam and the zero-run timer look at the registered count, giving one cycle of latency from count to flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count    <= '0;
            jam      <= 1'b0;
            zero_run <= '0;
            occ_err  <= 1'b0;
        end else begin
            if (arrive && !depart) begin
                if (count == CNT_MAX) occ_err <= 1'b1;
                else                  count   <= count + CNT_W'(1);
            end else if (depart && !arrive) begin
                if (count == '0) occ_err <= 1'b1;
                else             count   <= count - CNT_W'(1);
            end

            if (count >= JAM_ON_C)      jam <= 1'b1;
            else if (count < JAM_OFF_C) jam <= 1'b0;

            if (count != '0)            zero_run <= '0;
            else if (zero_run != HOLD_C) zero_run <= zero_run + EW'(1);
        end
    end

    assign empty = (zero_run == HOLD_C) && !jam;

endmodule

// File: rtl/traffic_sensor_encoder.sv
// Turns road-side arrive/depart pulses and siren levels into Emergency/Jam/Empty requests for the light controller.
// Define TRAFFIC_EMG_TIMEOUT_EN to bound each emergency grant to EMG_MAX cycles with a per-road lockout.
module traffic_sensor_encoder
    import traffic_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int JAM_ON     = DEF_JAM_ON,
    parameter int JAM_OFF    = DEF_JAM_OFF,
    parameter int EMPTY_HOLD = DEF_EMPTY_HOLD,
`ifdef TRAFFIC_EMG_TIMEOUT_EN
    parameter int EMG_MAX    = DEF_EMG_MAX,
`endif
    parameter int SIREN_HOLD = DEF_SIREN_HOLD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] arrive,
    input  logic [3:0] depart,
    input  logic [3:0] siren,
    output logic [3:0] Emergency,
    output logic [3:0] Jam,
    output logic [3:0] Empty,
    output logic [3:0] occ_err
);

    localparam int SW = $clog2(SIREN_HOLD + 1);
    localparam logic [SW-1:0] SIREN_HOLD_C = SW'(SIREN_HOLD);

    for (genvar i = 0; i < NUM_ROADS; i++) begin : g_road
        road_occupancy_channel #(
            .CNT_W      (CNT_W),
            .JAM_ON     (JAM_ON),
            .JAM_OFF    (JAM_OFF),
            .EMPTY_HOLD (EMPTY_HOLD)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .arrive  (arrive[i]),
            .depart  (depart[i]),
            .jam     (Jam[i]),
            .empty   (Empty[i]),
            .occ_err (occ_err[i])
        );
    end

    logic [SW-1:0] siren_run [NUM_ROADS];
    logic [3:0]    qualified;
    emg_state_t    state, state_n;
    logic [1:0]    active_road;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ROADS; i++) siren_run[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ROADS; i++) begin
                if (!siren[i])                          siren_run[i] <= '0;
                else if (siren_run[i] != SIREN_HOLD_C) siren_run[i] <= siren_run[i] + SW'(1);
            end
        end
    end

`ifdef TRAFFIC_EMG_TIMEOUT_EN
    localparam int TW = $clog2(EMG_MAX);
    localparam logic [TW-1:0] TMR_LAST = TW'(EMG_MAX - 1);

    logic [TW-1:0] grant_timer;
    logic [3:0]    lockout;
    logic          timed_out;

    assign timed_out = (state != EMG_IDLE) && (grant_timer == TMR_LAST);

    // A timed-out road stays locked until its siren has been seen low, so a stuck detector cannot hog the junction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_timer <= '0;
            lockout     <= '0;
        end else begin
            grant_timer <= (state == EMG_IDLE) ? '0 : grant_timer + TW'(1);
            for (int i = 0; i < NUM_ROADS; i++) begin
                if (!siren[i]) lockout[i] <= 1'b0;
            end
            if (timed_out && siren[active_road]) lockout[active_road] <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ROADS; i++) qualified[i] = (siren_run[i] == SIREN_HOLD_C) && !lockout[i];
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_ROADS; i++) qualified[i] = (siren_run[i] == SIREN_HOLD_C);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= EMG_IDLE;
        else      state <= state_n;
    end

    assign active_road = grant_road(state);

    // Grants are only chosen from IDLE, so a qualified road never preempts and always sees one IDLE cycle first.
    always_comb begin
        state_n = state;
        case (state)
            EMG_IDLE: begin
                if (qualified[ROAD_SOUTH])      state_n = EMG_SOUTH;
                else if (qualified[ROAD_WEST])  state_n = EMG_WEST;
                else if (qualified[ROAD_NORTH]) state_n = EMG_NORTH;
                else if (qualified[ROAD_EAST])  state_n = EMG_EAST;
            end
            default: begin
                if (!siren[active_road]) state_n = EMG_IDLE;
`ifdef TRAFFIC_EMG_TIMEOUT_EN
                else if (timed_out)      state_n = EMG_IDLE;
`endif
            end
        endcase
    end

    assign Emergency = (state == EMG_IDLE) ? 4'b0000 : road_onehot(active_road);

endmodule

// File: tb/tb_traffic_sensor_encoder.sv
// Directed self-checking bench for traffic_sensor_encoder; define TRAFFIC_EMG_TIMEOUT_EN to also exercise the grant timeout.
module tb_traffic_sensor_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] arrive, depart, siren;
    logic [3:0] Emergency, Jam, Empty, occ_err;

    int checks   = 0;
    int failures = 0;

    traffic_sensor_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .arrive    (arrive),
        .depart    (depart),
        .siren     (siren),
        .Emergency (Emergency),
        .Jam       (Jam),
        .Empty     (Empty),
        .occ_err   (occ_err)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; arrive = 4'b1010; depart = 4'b0101; siren = 4'b1111;
        step();
        arrive = 4'b0101; depart = 4'b1010; siren = 4'b0110;
        step();
        checks++;
        if (Emergency !== 4'b0000) begin failures++; $display("[TB] FAIL reset_emergency: got %b expected 0000", Emergency); end
        checks++;
        if (Jam !== 4'b0000) begin failures++; $display("[TB] FAIL reset_jam: got %b expected 0000", Jam); end
        checks++;
        if (Empty !== 4'b0000) begin failures++; $display("[TB] FAIL reset_empty: got %b expected 0000", Empty); end
        checks++;
        if (occ_err !== 4'b0000) begin failures++; $display("[TB] FAIL reset_occ_err: got %b expected 0000", occ_err); end
        rst = 1'b1; arrive = '0; depart = '0; siren = '0;
        step(7);
        checks++;
        if (Empty !== 4'b0000) begin failures++; $display("[TB] FAIL empty_early: got %b expected 0000", Empty); end
        step();
        checks++;
        if (Empty !== 4'b1111) begin failures++; $display("[TB] FAIL empty_hold: got %b expected 1111", Empty); end
    endtask

    task automatic test_jam();
        arrive = 4'b0010;
        step(20);
        arrive = '0;
        checks++;
        if (Jam !== 4'b0000) begin failures++; $display("[TB] FAIL jam_latency: got %b expected 0000", Jam); end
        step();
        checks++;
        if (Jam !== 4'b0010) begin failures++; $display("[TB] FAIL jam_set: got %b expected 0010", Jam); end
        checks++;
        if (Empty !== 4'b1101) begin failures++; $display("[TB] FAIL jam_empty: got %b expected 1101", Empty); end
        depart = 4'b0010;
        step(6);
        depart = '0;
        step();
        checks++;
        if (Jam !== 4'b0010) begin failures++; $display("[TB] FAIL jam_hold14: got %b expected 0010", Jam); end
        depart = 4'b0010;
        step();
        depart = '0;
        checks++;
        if (Jam !== 4'b0010) begin failures++; $display("[TB] FAIL jam_clear_latency: got %b expected 0010", Jam); end
        step();
        checks++;
        if (Jam !== 4'b0000) begin failures++; $display("[TB] FAIL jam_clear: got %b expected 0000", Jam); end
        depart = 4'b0010;
        step(13);
        depart = '0;
        step(10);
        checks++;
        if (Empty !== 4'b1111) begin failures++; $display("[TB] FAIL west_drained_empty: got %b expected 1111", Empty); end
    endtask

    task automatic test_counter_edges();
        depart = 4'b0001;
        step();
        depart = '0;
        checks++;
        if (occ_err !== 4'b0001) begin failures++; $display("[TB] FAIL floor_err: got %b expected 0001", occ_err); end
        step(2);
        checks++;
        if (Empty[0] !== 1'b1) begin failures++; $display("[TB] FAIL floor_empty: got %b expected 1", Empty[0]); end
        arrive = 4'b0001;
        step(5);
        arrive = 4'b0001; depart = 4'b0001;
        step();
        arrive = '0; depart = 4'b0001;
        step(4);
        depart = '0;
        step(10);
        checks++;
        if (Empty[0] !== 1'b0) begin failures++; $display("[TB] FAIL both_pulse_count: got Empty[0]=%b expected 0", Empty[0]); end
        checks++;
        if (occ_err !== 4'b0001) begin failures++; $display("[TB] FAIL both_pulse_err: got %b expected 0001", occ_err); end
        depart = 4'b0001;
        step();
        depart = '0;
        step(7);
        checks++;
        if (Empty[0] !== 1'b0) begin failures++; $display("[TB] FAIL requal_early: got %b expected 0", Empty[0]); end
        step();
        checks++;
        if (Empty[0] !== 1'b1) begin failures++; $display("[TB] FAIL requal_empty: got %b expected 1", Empty[0]); end
        arrive = 4'b1000;
        step(63);
        checks++;
        if (occ_err !== 4'b0001) begin failures++; $display("[TB] FAIL sat_early: got %b expected 0001", occ_err); end
        step();
        arrive = '0;
        checks++;
        if (occ_err !== 4'b1001) begin failures++; $display("[TB] FAIL sat_err: got %b expected 1001", occ_err); end
        checks++;
        if (Jam !== 4'b1000) begin failures++; $display("[TB] FAIL sat_jam: got %b expected 1000", Jam); end
        depart = 4'b1000;
        step(63);
        depart = '0;
        step(2);
        checks++;
        if (occ_err !== 4'b1001 || Jam !== 4'b0000) begin
            failures++; $display("[TB] FAIL east_drain: got occ_err=%b Jam=%b expected 1001/0000", occ_err, Jam);
        end
    endtask

    task automatic test_priority();
        siren = 4'b0101;
        step(4);
        checks++;
        if (Emergency !== 4'b0000) begin failures++; $display("[TB] FAIL prio_early: got %b expected 0000", Emergency); end
        step();
        checks++;
        if (Emergency !== 4'b0001) begin failures++; $display("[TB] FAIL prio_grant: got %b expected 0001", Emergency); end
        siren = 4'b0100;
        step();
        checks++;
        if (Emergency !== 4'b0000) begin failures++; $display("[TB] FAIL prio_release: got %b expected 0000", Emergency); end
        step();
        checks++;
        if (Emergency !== 4'b0100) begin failures++; $display("[TB] FAIL prio_next: got %b expected 0100", Emergency); end
        siren = '0;
        step();
        checks++;
        if (Emergency !== 4'b0000) begin failures++; $display("[TB] FAIL prio_done: got %b expected 0000", Emergency); end
    endtask

    task automatic test_no_preempt();
        siren = 4'b0100;
        step(5);
        checks++;
        if (Emergency !== 4'b0100) begin failures++; $display("[TB] FAIL north_grant: got %b expected 0100", Emergency); end
        siren = 4'b0101;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (Emergency !== 4'b0100) begin failures++; $display("[TB] FAIL no_preempt cycle %0d: got %b expected 0100", k, Emergency); end
        end
        siren = 4'b0001;
        step();
        checks++;
        if (Emergency !== 4'b0000) begin failures++; $display("[TB] FAIL north_release: got %b expected 0000", Emergency); end
        step();
        checks++;
        if (Emergency !== 4'b0001) begin failures++; $display("[TB] FAIL south_after: got %b expected 0001", Emergency); end
        siren = '0;
        step();
    endtask

`ifdef TRAFFIC_EMG_TIMEOUT_EN
    task automatic test_timeout();
        siren = 4'b1000;
        step(5);
        checks++;
        if (Emergency !== 4'b1000) begin failures++; $display("[TB] FAIL east_grant: got %b expected 1000", Emergency); end
        step(199);
        checks++;
        if (Emergency !== 4'b1000) begin failures++; $display("[TB] FAIL timeout_last: got %b expected 1000", Emergency); end
        step();
        checks++;
        if (Emergency !== 4'b0000) begin failures++; $display("[TB] FAIL timeout_release: got %b expected 0000", Emergency); end
        step(95);
        checks++;
        if (Emergency !== 4'b0000) begin failures++; $display("[TB] FAIL lockout_hold: got %b expected 0000", Emergency); end
        siren = '0;
        step();
        siren = 4'b1000;
        step(4);
        checks++;
        if (Emergency !== 4'b0000) begin failures++; $display("[TB] FAIL relock_early: got %b expected 0000", Emergency); end
        step();
        checks++;
        if (Emergency !== 4'b1000) begin failures++; $display("[TB] FAIL regrant: got %b expected 1000", Emergency); end
        siren = '0;
        step();
    endtask
`endif

    task automatic test_mid_reset();
        siren = 4'b0001; arrive = 4'b0100;
        step(5);
        arrive = '0;
        checks++;
        if (Emergency !== 4'b0001) begin failures++; $display("[TB] FAIL pre_reset_grant: got %b expected 0001", Emergency); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (Emergency !== 4'b0000 || occ_err !== 4'b0000 || Jam !== 4'b0000 || Empty !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL mid_reset: got E=%b J=%b Em=%b err=%b expected all 0000", Emergency, Jam, Empty, occ_err);
        end
        step(4);
        checks++;
        if (Emergency !== 4'b0000) begin failures++; $display("[TB] FAIL post_reset_requal: got %b expected 0000", Emergency); end
        step();
        checks++;
        if (Emergency !== 4'b0001) begin failures++; $display("[TB] FAIL post_reset_grant: got %b expected 0001", Emergency); end
        siren = '0;
        step();
    endtask

    initial begin
        rst = 1'b0; arrive = '0; depart = '0; siren = '0;
        test_reset();
        test_jam();
        test_counter_edges();
        test_priority();
        test_no_preempt();
`ifdef TRAFFIC_EMG_TIMEOUT_EN
        test_timeout();
`endif
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_encoder.md
Name: traffic_sensor_encoder

Overview:
- Produces the per-road `Emergency`, `Jam` and `Empty` request vectors that drive `traffic_light_controller`.
- Raw inputs come from road-side sensors: vehicle arrival and departure pulses, plus siren detectors.
- Keeps a per-road occupancy count, qualifies jam/empty with thresholds and hold timers, and debounces sirens into a one-hot emergency grant.
- Sits between the sensor front-end and the controller, in the same clock domain.

Parameters:
- CNT_W, 6: occupancy counter width per road.
- JAM_ON, 20: occupancy at or above which `Jam` asserts.
- JAM_OFF, 14: occupancy below which `Jam` deasserts (hysteresis). Must be less than JAM_ON.
- EMPTY_HOLD, 8: consecutive zero-occupancy cycles required before `Empty` asserts.
- SIREN_HOLD, 4: consecutive siren-high cycles required to qualify an emergency.
- EMG_MAX, 200: emergency grant timeout in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset, 1 = normal operation).
- arrive  in  4  one-cycle vehicle-arrival pulses per road.
- depart  in  4  one-cycle vehicle-departure pulses per road.
- siren  in  4  level siren detect per road.
- Emergency  out  4  one-hot (or zero) emergency request to the controller.
- Jam  out  4  jam request per road.
- Empty  out  4  empty-road indication per road.
- occ_err  out  4  sticky per road: set on a depart while the count is 0, or an arrive at saturation.
- Road bit mapping is fixed for all 4-bit vectors: bit0 South, bit1 West, bit2 North, bit3 East.

Behaviour:
- Reset (rst=0 sampled at a clk edge):
  - All counters, timers, `Emergency`, `Jam` and `occ_err` clear to 0.
  - `Empty` resets to 4'b0000; the hold timer must requalify after reset.
  - Reset mid-operation discards all in-flight qualification and any active grant.
- Occupancy counter, per road:
  - arrive&!depart → +1, saturating at 2^CNT_W-1.
  - depart&!arrive → -1, saturating at 0.
  - Both asserted, or neither → count unchanged.
  - A saturated increment or a floored decrement sets `occ_err[i]`; it clears only on reset.
- Jam, per road:
  - Registered.
  - Sets the cycle after the count reaches ≥ JAM_ON.
  - Clears the cycle after the count drops < JAM_OFF.
  - Holds otherwise.
- Empty, per road:
  - A zero-run timer increments while count==0, saturating at EMPTY_HOLD.
  - `Empty[i]` = 1 once the timer == EMPTY_HOLD.
  - Any nonzero count clears both the timer and `Empty[i]` on the next edge.
  - `Jam[i]` and `Empty[i]` are never both 1.
- Siren qualifier, per road:
  - A run counter increments while `siren[i]` = 1 and resets when it is 0.
  - The road is qualified when the counter reaches SIREN_HOLD.
- Emergency grant FSM:
  - States: IDLE, GRANT(road).
  - IDLE → GRANT(r) when any road is qualified. If several qualify in the same cycle, the lowest bit wins: South > West > North > East.
  - In GRANT(r), `Emergency` = one-hot r, registered (1 cycle after qualification).
  - GRANT(r) → IDLE when `siren[r]` = 0. `Emergency` drops on the next edge.
  - Other qualified roads never preempt an active grant. After returning to IDLE, a still-qualified road is granted after one IDLE cycle.
  - `Emergency` is never multi-hot.
- Latency:
  - Pulse to count update: 1 cycle.
  - Count to `Jam`/`Empty`: 1 cycle.
  - Siren rise to `Emergency`: SIREN_HOLD + 1 cycles.

Optional Feature:
- Macro: TRAFFIC_EMG_TIMEOUT_EN.
- Defined:
  - GRANT counts cycles. At EMG_MAX cycles the FSM forces IDLE and sets a per-road lockout bit.
  - A locked-out road cannot qualify until its siren has been low for at least 1 cycle.
- Undefined: a grant lasts until its siren drops; EMG_MAX is unused.

Decomposition:
- Shared package `traffic_pkg`:
  - Road index constants ROAD_SOUTH=0, ROAD_WEST=1, ROAD_NORTH=2, ROAD_EAST=3.
  - Emergency FSM state encoding.
  - Default threshold constants.
- One natural sub-module, `road_occupancy_channel`:
  - Contains the counter, jam hysteresis, empty hold timer and occ_err.
  - Instantiated 4 times.
- Siren qualifiers and the grant FSM stay in the top module.

Test Plan:
- Reset: rst=0 for 2 cycles, with arrive/depart/siren toggling → all outputs 0. After rst=1 with no traffic → `Empty`=4'b1111 exactly 8 cycles after the first post-reset zero-count cycle.
- Jam hysteresis: 20 arrive pulses on West → `Jam`=4'b0010 one cycle after the 20th. Then 6 departs (count 14) → still set. 7th depart → clears next cycle.
- Counter edges: depart on South at count 0 → count stays 0, `occ_err[0]`=1. Simultaneous arrive+depart at count 5 → count stays 5.
- Emergency priority: siren=4'b0101 rising together → `Emergency`=4'b0001 at cycle 5. Drop siren[0] → 4'b0000 one cycle later, then 4'b0100 after one IDLE cycle.
- No preemption: North granted, then South siren held 10 cycles → `Emergency` stays 4'b0100 until siren[2] drops.
- Timeout (with TRAFFIC_EMG_TIMEOUT_EN, EMG_MAX=200): East siren held 300 cycles → grant released after 200 cycles and not re-granted until the siren goes low then high again.
